// File: rtl/sincos_cordic.sv
// sincos_cordic: iterative CORDIC sine/cosine generator.
//
// A signed Q(FRAC_BITS) angle in radians is accepted through a valid/ready
// handshake. It is brought into [-pi, pi] and folded into [-pi/2, pi/2], with
// cos negated for the folded half-planes. It is then rotated one
// micro-rotation per cycle. The result is held until the consumer takes it.
//
// Optional feature macro: SINCOS_RANGE_REDUCE_EN
//   defined   : a REDUCE state removes 2*pi one step per cycle, so any signed
//               WIDTH-bit angle is accepted.
//   undefined : one conditional 2*pi wrap at accept time; the input range is
//               [-pi, 3*pi].
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   in_valid   angle presented
//   in_ready   block idle, can accept an angle
//   angle      signed radians, Q(FRAC_BITS)
//   out_valid  sin/cos valid, held until out_ready
//   out_ready  consumer accepts the result
//   sin, cos   signed results, Q(FRAC_BITS), saturated to +/-1.0
//   busy       an operation is in flight (state != IDLE)

module sincos_cordic #(
    parameter int WIDTH     = 27,
    parameter int FRAC_BITS = 8,
    parameter int ITERS     = 12,   // legal range 4..WIDTH-2
    parameter int GUARD     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] angle,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] sin,
    output logic signed [WIDTH-1:0] cos,
    output logic                    busy
);

    localparam int  DW   = WIDTH + GUARD;
    localparam int  IW   = $clog2(ITERS);
    localparam real PI_R = 3.14159265358979323846;

    localparam int PI_I = $rtoi(PI_R * (2.0 ** FRAC_BITS) + 0.5);
    localparam logic signed [WIDTH-1:0] PI_Q      = WIDTH'(PI_I);
    localparam logic signed [WIDTH-1:0] TWO_PI_Q  = WIDTH'(2 * PI_I);
    localparam logic signed [WIDTH-1:0] HALF_PI_Q = WIDTH'(PI_I / 2);

    // Start x at 1/K so the rotation gain comes out as 1.0.
    localparam logic signed [DW-1:0] X_INIT =
        DW'($rtoi(0.6072529 * (2.0 ** (FRAC_BITS + GUARD)) + 0.5));
    localparam logic signed [DW-1:0] ONE_Q    = DW'(2 ** FRAC_BITS);
    localparam logic signed [DW-1:0] HALF_LSB = DW'((2 ** GUARD) / 2);
    localparam logic [IW-1:0]        LAST     = IW'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, REDUCE, ROTATE, DONE} state_t;

    state_t                 state;
    logic [IW-1:0]          i;
    logic signed [DW-1:0]   x, y, z;
    logic signed [DW-1:0]   x_nxt, y_nxt, z_nxt;
    logic                   neg;
    logic signed [WIDTH-1:0] fold_src, fold_z;
    logic                   fold_neg;
`ifdef SINCOS_RANGE_REDUCE_EN
    logic signed [WIDTH-1:0] a;
`endif

    // atan(2^-i) in Q(FRAC_BITS+GUARD), built at elaboration.
    logic signed [DW-1:0] atan_tab [ITERS];
    for (genvar g = 0; g < ITERS; g++) begin : g_atan
        localparam real ATAN_R = $atan(2.0 ** (-g));
        assign atan_tab[g] = DW'($rtoi(ATAN_R * (2.0 ** (FRAC_BITS + GUARD)) + 0.5));
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Quadrant fold of an angle already in [-pi, pi]: the result lies in
    // [-pi/2, pi/2]. sin(pi - a) = sin(a) while cos changes sign.
    always_comb begin
`ifdef SINCOS_RANGE_REDUCE_EN
        fold_src = a;
`else
        fold_src = (angle > PI_Q) ? angle - TWO_PI_Q : angle;
`endif
        fold_z   = fold_src;
        fold_neg = 1'b0;
        if (fold_src > HALF_PI_Q) begin
            fold_z   = PI_Q - fold_src;
            fold_neg = 1'b1;
        end else if (fold_src < -HALF_PI_Q) begin
            fold_z   = -PI_Q - fold_src;
            fold_neg = 1'b1;
        end
    end

    // One micro-rotation, driven toward z = 0.
    always_comb begin
        if (!z[DW-1]) begin
            x_nxt = x - (y >>> i);
            y_nxt = y + (x >>> i);
            z_nxt = z - atan_tab[i];
        end else begin
            x_nxt = x + (y >>> i);
            y_nxt = y - (x >>> i);
            z_nxt = z + atan_tab[i];
        end
    end

    // Drop guard bits (round half up), optionally negate, clamp to +/-1.0.
    function automatic logic signed [WIDTH-1:0] out_round(
        input logic signed [DW-1:0] v,
        input logic                 negate
    );
        logic signed [DW-1:0] r;
        r = (v + HALF_LSB) >>> GUARD;
        if (negate) r = -r;
        if (r > ONE_Q)       r = ONE_Q;
        else if (r < -ONE_Q) r = -ONE_Q;
        return r[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            i     <= '0;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            neg   <= 1'b0;
            sin   <= '0;
            cos   <= '0;
`ifdef SINCOS_RANGE_REDUCE_EN
            a     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef SINCOS_RANGE_REDUCE_EN
                        a     <= angle;
                        state <= REDUCE;
`else
                        x     <= X_INIT;
                        y     <= '0;
                        z     <= DW'(fold_z) <<< GUARD;
                        neg   <= fold_neg;
                        i     <= '0;
                        state <= ROTATE;
`endif
                    end
                end
                REDUCE: begin
`ifdef SINCOS_RANGE_REDUCE_EN
                    // One 2*pi correction per cycle; fold once in range.
                    if (a > PI_Q) begin
                        a <= a - TWO_PI_Q;
                    end else if (a < -PI_Q) begin
                        a <= a + TWO_PI_Q;
                    end else begin
                        x     <= X_INIT;
                        y     <= '0;
                        z     <= DW'(fold_z) <<< GUARD;
                        neg   <= fold_neg;
                        i     <= '0;
                        state <= ROTATE;
                    end
`else
                    state <= IDLE;
`endif
                end
                ROTATE: begin
                    x <= x_nxt;
                    y <= y_nxt;
                    z <= z_nxt;
                    if (i == LAST) begin
                        // Outputs come from the final rotation's results.
                        sin   <= out_round(y_nxt, 1'b0);
                        cos   <= out_round(x_nxt, neg);
                        i     <= '0;
                        state <= DONE;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sincos_cordic.sv
// tb_sincos_cordic: self-checking bench for sincos_cordic at default
// parameters. It uses a vector table with fixed bounds, random angles
// compared against real-valued sin/cos of the reduced angle, and hand
// sequences for back-pressure and a reset that arrives in the middle of an
// operation.

module tb_sincos_cordic;

    localparam int WIDTH = 27;
`ifdef SINCOS_RANGE_REDUCE_EN
    localparam int LAT0 = 14;
    localparam int ROT5 = 7;   // cycle after transfer holding rotation i=5
`else
    localparam int LAT0 = 13;
    localparam int ROT5 = 6;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] angle;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] sin;
    logic signed [WIDTH-1:0] cos;
    logic                    busy;

    int tests = 0;
    int fails = 0;

    sincos_cordic dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .angle    (angle),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sin      (sin),
        .cos      (cos),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ang;
        int s_lo, s_hi, c_lo, c_hi;
    } vec_t;

    task automatic chk(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, want [%0d,%0d]", name, act, lo, hi);
        end
    endtask

    // Reference reduction: the angle the block should rotate by, and the
    // number of 2*pi corrections spent getting there.
    function automatic int reduce_ang(input int a, output int n);
        n = 0;
`ifdef SINCOS_RANGE_REDUCE_EN
        while (a > 804)  begin a -= 1608; n++; end
        while (a < -804) begin a += 1608; n++; end
`else
        if (a > 804) a -= 1608;
`endif
        return a;
    endfunction

    task automatic start_op(input int ang);
        for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk);
        chk("in_ready before start", int'(in_ready), 1, 1);
        angle    = WIDTH'(ang);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Returns the cycle (1 = first cycle after the transfer edge) in which
    // out_valid is first seen, or -1 on timeout.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_one(input int ang, output int s, output int c, output int lat);
        start_op(ang);
        wait_out(lat);
        s = int'(sin);
        c = int'(cos);
        if (lat > 0) release_out();
    endtask

    initial begin
        vec_t vecs[$];
        int s, c, lat, n, red, hs, hc, seen;
        real is_r, ic_r;

        vecs.push_back('{0,       -2,    2,  254,  256});
        vecs.push_back('{402,    254,  256,   -2,    2});
        vecs.push_back('{-402,  -256, -254,   -2,    2});
        vecs.push_back('{804,     -2,    2, -256, -254});
        vecs.push_back('{-804,    -2,    2, -256, -254});
        vecs.push_back('{201,    179,  183,  179,  183});
        vecs.push_back('{1809,   179,  183,  179,  183});
        vecs.push_back('{2412,    -2,    2, -256, -254});
`ifdef SINCOS_RANGE_REDUCE_EN
        vecs.push_back('{5025,   179,  183,  179,  183});
        vecs.push_back('{-5025, -183, -179,  179,  183});
`endif

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; angle = '0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", int'(out_valid), 0, 0);
        chk("reset busy", int'(busy), 0, 0);
        chk("reset sin", int'(sin), 0, 0);
        chk("reset cos", int'(cos), 0, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", int'(in_ready), 1, 1);

        foreach (vecs[k]) begin
            red = reduce_ang(vecs[k].ang, n);
            run_one(vecs[k].ang, s, c, lat);
            chk($sformatf("vec %0d sin", vecs[k].ang), s, vecs[k].s_lo, vecs[k].s_hi);
            chk($sformatf("vec %0d cos", vecs[k].ang), c, vecs[k].c_lo, vecs[k].c_hi);
            chk($sformatf("vec %0d latency", vecs[k].ang), lat, LAT0 + n, LAT0 + n);
        end

        for (int r = 0; r < 40; r++) begin
            int ang;
`ifdef SINCOS_RANGE_REDUCE_EN
            ang = int'($urandom_range(0, 40000)) - 20000;
`else
            ang = int'($urandom_range(0, 3216)) - 804;
`endif
            red  = reduce_ang(ang, n);
            is_r = $sin(real'(red) / 256.0) * 256.0;
            ic_r = $cos(real'(red) / 256.0) * 256.0;
            run_one(ang, s, c, lat);
            chk($sformatf("rand %0d sin", ang), s, $rtoi($ceil(is_r - 2.0)), $rtoi($floor(is_r + 2.0)));
            chk($sformatf("rand %0d cos", ang), c, $rtoi($ceil(ic_r - 2.0)), $rtoi($floor(ic_r + 2.0)));
            chk($sformatf("rand %0d latency", ang), lat, LAT0 + n, LAT0 + n);
        end

        // Back-pressure: the result holds and new requests are ignored.
        start_op(402);
        wait_out(lat);
        chk("bp latency", lat, LAT0, LAT0);
        hs = int'(sin);
        hc = int'(cos);
        chk("bp sin", hs, 254, 256);
        for (int k = 0; k < 5; k++) begin
            angle    = WIDTH'(-402);
            in_valid = (k % 2) == 0;
            @(negedge clk);
            chk("bp out_valid held", int'(out_valid), 1, 1);
            chk("bp sin stable", int'(sin), hs, hs);
            chk("bp cos stable", int'(cos), hc, hc);
            chk("bp in_ready low", int'(in_ready), 0, 0);
        end
        in_valid = 1'b0;
        release_out();
        chk("bp in_ready after accept", int'(in_ready), 1, 1);
        chk("bp out_valid after accept", int'(out_valid), 0, 0);
        repeat (3) @(negedge clk);
        chk("bp no ghost operation", int'(busy), 0, 0);

        // Reset arriving at rotation 5 discards the operation.
        start_op(201);
        repeat (ROT5) @(negedge clk);
        chk("mid busy", int'(busy), 1, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid reset out_valid", int'(out_valid), 0, 0);
        chk("mid reset sin", int'(sin), 0, 0);
        chk("mid reset cos", int'(cos), 0, 0);
        chk("mid reset in_ready", int'(in_ready), 1, 1);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid reset no stale result", seen, 0, 0);

        // The block still works after the abort.
        run_one(-402, s, c, lat);
        chk("post reset sin", s, -256, -254);
        chk("post reset latency", lat, LAT0, LAT0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sincos_cordic.md
SINCOS_CORDIC -- requirements
Module: sincos_cordic

Interface
REQ-001 Parameter WIDTH, default 27: width of the signed angle input and the sin/cos outputs.
REQ-002 Parameter FRAC_BITS, default 8: fractional bits of angle and outputs. 1.0 = 2^FRAC_BITS; 256 at default.
REQ-003 Parameter ITERS, default 12: number of CORDIC micro-rotations; legal range 4..WIDTH-2.
REQ-004 Parameter GUARD, default 2: extra LSBs carried in the internal x/y/z datapath.
REQ-005 clk  input  1  clock; the block has exactly one clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  angle is presented.
REQ-008 in_ready  output  1  block can accept an angle.
REQ-009 angle  input  WIDTH  signed radians, Q(FRAC_BITS).
REQ-010 out_valid  output  1  sin/cos are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sin  output  WIDTH  signed sine, Q(FRAC_BITS).
REQ-013 cos  output  WIDTH  signed cosine, Q(FRAC_BITS).
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The following constants SHALL be elaboration-time values, each rounded to nearest at FRAC_BITS: PI_Q = round(pi*2^FRAC_BITS), TWO_PI_Q = 2*PI_Q, HALF_PI_Q = PI_Q/2. Defaults are 804, 1608 and 402.
REQ-016 The arctangent table SHALL contain ITERS entries, round(atan(2^-i)*2^(FRAC_BITS+GUARD)), for i = 0..ITERS-1.
REQ-017 The initial x SHALL be round(0.6072529*2^(FRAC_BITS+GUARD)) and the initial y SHALL be 0.
REQ-018 FSM states SHALL be IDLE, REDUCE, ROTATE and DONE.
REQ-019 in_ready SHALL equal (state == IDLE).
REQ-020 A transfer occurs on the edge where in_valid && in_ready; angle SHALL be sampled only on that edge.
REQ-021 On transfer the block SHALL go to REDUCE, or to ROTATE when REDUCE is compiled out (see REQ-034/035).
REQ-022 Quadrant fold SHALL be applied to the reduced angle a, which lies in [-PI_Q, PI_Q].
REQ-023 Fold when a > HALF_PI_Q: z = PI_Q - a and a cos-negate flag is set.
REQ-024 Fold when a < -HALF_PI_Q: z = -PI_Q - a and the cos-negate flag is set.
REQ-025 In all other cases z = a and the flag is cleared.
REQ-026 ROTATE SHALL perform one micro-rotation per cycle, counter i = 0..ITERS-1: if z >= 0 then x -= y>>>i, y += x>>>i, z -= atan[i]; otherwise the opposite signs. All shifts are arithmetic.
REQ-027 After iteration ITERS-1 the block SHALL go to DONE.
REQ-028 On DONE entry, sin and cos SHALL be registered: drop GUARD bits with round-half-up, negate cos if the flag is set, saturate to [-2^FRAC_BITS, +2^FRAC_BITS].
REQ-029 out_valid SHALL equal (state == DONE). sin and cos SHALL stay stable while out_valid && !out_ready.
REQ-030 On out_valid && out_ready the block SHALL return to IDLE. in_ready rises on the following cycle; there is no same-cycle re-accept.
REQ-031 Latency with no reduction steps SHALL be: out_valid high exactly ITERS+1 cycles after the transfer edge, plus 1 cycle when REDUCE is compiled in.
REQ-032 Accuracy SHALL be |sin - ideal| <= 2 LSB and |cos - ideal| <= 2 LSB at default parameters, for every reduced angle.

Reset
REQ-033 While reset is high at an edge: state = IDLE, sin = 0, cos = 0, out_valid = 0, busy = 0, i = 0. in_ready SHALL be 1 from the first cycle after reset. A reset mid-REDUCE, ROTATE or DONE SHALL abort and discard the operation with no output transfer.

Configuration
REQ-034 With macro SINCOS_RANGE_REDUCE_EN defined: REDUCE SHALL take one cycle per step.
- While a > PI_Q: a -= TWO_PI_Q.
- While a < -PI_Q: a += TWO_PI_Q.
- A cycle in which a is already within [-PI_Q, PI_Q] performs the fold and goes to ROTATE.
- Any signed WIDTH-bit angle is accepted.
- Latency = ITERS + 2 + N cycles, where N is the number of 2*pi corrections.
REQ-035 Without the macro there is no REDUCE state. At transfer, a single conditional wrap is applied (if angle > PI_Q then angle -= TWO_PI_Q), and the fold and ROTATE follow directly. Input SHALL be within [-PI_Q, 3*PI_Q]; results outside that range are unspecified.

Verification
REQ-036 angle = 0 -> sin in [-2, 2], cos in [254, 256]; out_valid exactly 13 cycles after the transfer without the macro, 14 with it.
REQ-037 angle = 402 -> sin in [254, 256], cos in [-2, 2]. angle = -402 -> sin in [-256, -254].
REQ-038 angle = 804 -> sin in [-2, 2], cos in [-256, -254], with the cos-negate path exercised.
REQ-039 With SINCOS_RANGE_REDUCE_EN: angle = 3*1608 + 201 = 5025 -> sin and cos both in [179, 183]; out_valid 3 cycles later than for angle = 201. angle = -5025 -> sin in [-183, -179].
REQ-040 Hold out_ready = 0 for 5 cycles in DONE -> sin, cos and out_valid stable; in_ready = 0; in_valid pulses are ignored. Then assert out_ready for 1 cycle -> in_ready = 1 on the next cycle.
REQ-041 Assert reset at ROTATE iteration 5 -> the next cycle shows out_valid = 0, sin = cos = 0, in_ready = 1, and no stale result ever appears.
